muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Executes signed and unsigned multiply and divide over WIDTH bits and holds the results in internal HI/LO registers.
- Uses a start/busy/done handshake so the pipeline hazard unit can stall dependent instructions (mfhi/mflo, next mult/div) while busy.
- Also services single-cycle HI/LO writes (mthi/mtlo).

Parameters:
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op.
- a  input  WIDTH  operand A (multiplicand/dividend/mthi-mtlo data).
- b  input  WIDTH  operand B (multiplier/divisor).
- cancel  input  1  aborts an in-flight MULT/DIV (exception flush).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Deassertion is synchronous to clk. Reset mid-operation discards the operation and leaves HI/LO = 0.
- States and transitions:
  - IDLE → CALC on start with op MULT/MULTU/DIV/DIVU.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE.
- Accept edge E0 (IDLE, start=1):
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch result sign flags: product sign = a^b MSB; quotient sign = a^b MSB; remainder sign = a MSB.
  - counter=0; busy=1 after E0.
- CALC: one iteration per cycle.
  - Multiply: shift-add, 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract.
  - Counter increments; leaves CALC at the edge where counter reaches WIDTH-1.
- FIX (one cycle):
  - Apply two's-complement negation per the sign flags.
  - Write HI/LO at edge E0+WIDTH+1; busy falls at that edge; done=1 for exactly the following cycle.
  - Total latency WIDTH+1 cycles. HI/LO are unchanged before the FIX edge.
- Multiply result: {hi,lo} = full 2·WIDTH-bit product.
- Divide result: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): no special path. The raw algorithm yields quotient all-ones and remainder = a (unsigned). For DIV, sign fixup is then applied as normal. Same latency.
- Signed overflow (DIV, a = most-negative, b = -1): lo = most-negative value, hi = 0.
- MTHI/MTLO in IDLE: hi (resp. lo) = a at E0; busy stays 0; no done pulse.
- start while busy=1 (any op): ignored, no effect.
- Undefined op codes: ignored.
- cancel=1 in CALC or FIX: return to IDLE at the next edge; busy=0; HI/LO unchanged; no done. cancel has priority over the FIX write.
- cancel in IDLE: no effect. Simultaneous start+cancel in IDLE: the start is accepted.
- done and start in the same cycle: the start is accepted (busy=0 in that cycle).

Test Plan:
- Reset: assert rst_n=0 mid-CALC of MULTU → busy=0, done=0, hi=lo=0 immediately; no later done pulse.
- MULT a=7, b=-3 (0xFFFFFFFD), WIDTH=32 → busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5, normal latency. Then MTHI a=0x1234 → hi=0x1234 next edge, busy stays 0, no done.
- During MULT: start(DIVU) at cycle 5 ignored; cancel at cycle 10 → busy=0 next edge, HI/LO keep prior values. Back-to-back: start issued in the done cycle is accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// Shift-add multiply, restoring divide, one bit per cycle plus a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic               is_div;
  logic               neg_s;
  logic               neg_r;

  logic               md_op;
  logic               sgn;
  logic [WIDTH-1:0]   ua;
  logic [WIDTH-1:0]   ub;

  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     dtry;
  logic [2*WIDTH-1:0] mul_nx;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   qf;
  logic [WIDTH-1:0]   rf;

  assign md_op = ~op[2];
  assign sgn   = ~op[0];
  assign ua    = (sgn && a[WIDTH-1]) ? -a : a;
  assign ub    = (sgn && b[WIDTH-1]) ? -b : b;

  // multiply: acc = {partial, multiplier}, LSB of acc selects the add
  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc[0] ? dvs : {WIDTH{1'b0}})};
  assign mul_nx = {msum, acc[WIDTH-1:1]};

  // divide: acc = {remainder, dividend/quotient}, trial on shifted rem
  assign dtry   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  assign div_nx = dtry[WIDTH]
                ? {acc[2*WIDTH-2:0], 1'b0}
                : {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod = neg_s ? -acc : acc;
  assign qf   = neg_s ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rf   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && md_op) state_nx = CALC;
      CALC: begin
        if (cancel)           state_nx = IDLE;
        else if (cnt == LAST) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      neg_s  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              md_op: begin
                cnt    <= '0;
                is_div <= op[1];
                neg_s  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn & op[1] & a[WIDTH-1];
                acc    <= {{WIDTH{1'b0}}, (op[1] ? ua : ub)};
                dvs    <= op[1] ? ub : ua;
              end
              (op == OP_MTHI): hi <= a;
              (op == OP_MTLO): lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (!cancel) begin
            acc <= is_div ? div_nx : mul_nx;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rf;
              lo <= qf;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
